// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I main controller:
// state enum, opcodes, datapath mux encodings and per-state control decode.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_LNK,
    S_LUI, S_AUIPC, S_HALT, S_TRAP, S_BUSERR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       memreq;
    logic       adrsrc;
    logic       irwrite;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
    logic       halt;
    logic       illegal;
    logic       buserr;
  } ctrl_t;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // Completion-qualified strobes (irwrite/pcupdate in FETCH, memwrite) are gated in the top.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memreq = 1'b1; c.irwrite = 1'b1; c.pcupdate = 1'b1;
        c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURESULT;
      end
      S_DECODE:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
      S_MEMADR:   begin c.alusrca = SRCA_A; c.alusrcb = SRCB_IMM; end
      S_MEMREAD:  begin c.memreq = 1'b1; c.adrsrc = 1'b1; end
      S_MEMWB:    begin c.resultsrc = RES_DATA; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.memreq = 1'b1; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECR:    begin c.alusrca = SRCA_A; c.alusrcb = SRCB_RS2; c.aluop = ALUOP_FUNCT; end
      S_EXECI:    begin c.alusrca = SRCA_A; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_FUNCT; end
      S_ALUWB:    begin c.resultsrc = RES_ALUOUT; c.regwrite = 1'b1; end
      S_BRANCH: begin
        c.alusrca = SRCA_A; c.alusrcb = SRCB_RS2; c.aluop = ALUOP_BR;
        c.resultsrc = RES_ALUOUT; c.branch = 1'b1;
      end
      S_JAL, S_JALR_LNK: begin
        c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR;
        c.resultsrc = RES_ALUOUT; c.pcupdate = 1'b1;
      end
      S_JALR_ADR: begin c.alusrca = SRCA_A; c.alusrcb = SRCB_IMM; end
      S_LUI:      begin c.alusrca = SRCA_ZERO; c.alusrcb = SRCB_IMM; end
      S_AUIPC:    begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
      S_HALT:     c.halt = 1'b1;
      S_TRAP:     c.illegal = 1'b1;
      S_BUSERR:   c.buserr = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Memory wait watchdog: counts stalled cycles in a memory state and flags
// expiry once MAX_WAIT stalled cycles have accumulated since the last clear.
module mc_mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // Saturates at MAX_WAIT so the count can never wrap back to a safe value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (tick && (count != CW'(MAX_WAIT)))
      count <= count + 1'b1;
  end

  assign expired = (count == CW'(MAX_WAIT));

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback with a memory handshake, wait watchdog and illegal-opcode trap.
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit WAIT_STATES_EN = 1'b1,
  parameter int MAX_WAIT       = 15,
  parameter bit TRAP_ILLEGAL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic       Halt,
  output logic       Illegal,
  output logic       BusErr
);

  state_t state, next;
  ctrl_t  ctrl_q;
  logic   done, expired, strobe_gate;

  assign done = !WAIT_STATES_EN || MemReady;

  // Any state change restarts the watchdog, so each memory state starts counting from zero.
  mc_mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (next != state),
    .tick    (WAIT_STATES_EN && is_mem_state(state) && !MemReady),
    .expired (expired)
  );

  always_comb begin
    next = state;
    case (state)
      S_RST:   next = S_FETCH;
      S_FETCH: begin
        if (done)         next = S_DECODE;
        else if (expired) next = S_BUSERR;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R:              next = S_EXECR;
          OP_I:              next = S_EXECI;
          OP_BRANCH:         next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          OP_JALR:           next = S_JALR_ADR;
          OP_LUI:            next = S_LUI;
          OP_AUIPC:          next = S_AUIPC;
          OP_SYSTEM:         next = S_HALT;
          default:           next = TRAP_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:  next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (done)         next = S_MEMWB;
        else if (expired) next = S_BUSERR;
      end
      S_MEMWRITE: begin
        if (done)         next = S_FETCH;
        else if (expired) next = S_BUSERR;
      end
      S_MEMWB, S_ALUWB, S_BRANCH:                     next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR_LNK, S_LUI, S_AUIPC: next = S_ALUWB;
      S_JALR_ADR:                                    next = S_JALR_LNK;
      S_HALT, S_TRAP, S_BUSERR:                      next = state;
      default:                                       next = S_RST;
    endcase
  end

  // Control word is registered alongside the state, so it always reflects the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_RST;
      ctrl_q <= '0;
    end else begin
      state  <= next;
      ctrl_q <= state_ctrl(next);
    end
  end

  // Strobes of a memory state fire only in the cycle the access completes.
  assign strobe_gate = done || !ctrl_q.memreq;

  assign MemReq    = ctrl_q.memreq;
  assign AdrSrc    = ctrl_q.adrsrc;
  assign IRWrite   = ctrl_q.irwrite  && strobe_gate;
  assign PCUpdate  = ctrl_q.pcupdate && strobe_gate;
  assign MemWrite  = ctrl_q.memwrite && strobe_gate;
  assign Branch    = ctrl_q.branch;
  assign RegWrite  = ctrl_q.regwrite;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  assign ALUOp     = ctrl_q.aluop;
  assign ResultSrc = ctrl_q.resultsrc;
  assign ImmSrc    = imm_sel(op);
  assign Halt      = ctrl_q.halt;
  assign Illegal   = ctrl_q.illegal;
  assign BusErr    = ctrl_q.buserr;

endmodule
